// File: rtl/stage_memory_pkg.sv
// Shared memory-stage definitions: FSM states, exception codes, funct3 encodings,
// instruction-type codes (shared with the ROB), and address alignment helpers.
// Ports: none (package).
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } mem_state_e;

    localparam logic [2:0] EXC_NONE       = 3'd0;
    localparam logic [2:0] EXC_MISALIGNED = 3'd4;
    localparam logic [2:0] EXC_DTLB_MISS  = 3'd5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // funct3[1:0] carries the access size for both loads and stores
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [2:0] ITYPE_ALU    = 3'd0;
    localparam logic [2:0] ITYPE_LOAD   = 3'd1;
    localparam logic [2:0] ITYPE_STORE  = 3'd2;
    localparam logic [2:0] ITYPE_BRANCH = 3'd3;

    // Clear the address bits below the access size.
    function automatic logic [31:0] align_addr(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] r;
        r = a;
        if (f3[1:0] == SZ_HALF) begin
            r[0] = 1'b0;
        end else if (f3[1:0] == SZ_WORD) begin
            r[1:0] = 2'b00;
        end
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == SZ_HALF) && lo[0]) || ((f3[1:0] == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables and store-lane replication for the request,
// load-lane extraction with sign/zero extension for the response. No state, zero latency.
// Ports: req_funct3/req_offset/req_data -> req_byte_en/req_wdata; ld_funct3/ld_offset/ld_rdata -> ld_data.
module mem_align
    import mem_pkg::*;
(
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_offset,
    input  logic [31:0] req_data,
    output logic [3:0]  req_byte_en,
    output logic [31:0] req_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;

    always_comb begin
        req_byte_en = 4'b0000;
        req_wdata   = req_data;
        case (req_funct3[1:0])
            SZ_BYTE: begin
                req_byte_en = 4'b0001 << req_offset;
                req_wdata   = {4{req_data[7:0]}};
            end
            SZ_HALF: begin
                req_byte_en = 4'b0011 << {req_offset[1], 1'b0};
                req_wdata   = {2{req_data[15:0]}};
            end
            SZ_WORD: begin
                req_byte_en = 4'b1111;
            end
            default: begin
                req_byte_en = 4'b0000;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending.
    assign ld_shifted = ld_rdata >> {ld_offset, 3'b000};

    always_comb begin
        ld_data = ld_rdata;
        case (ld_funct3)
            F3_LB:   ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            F3_LH:   ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            F3_LW:   ld_data = ld_rdata;
            F3_LBU:  ld_data = {24'd0, ld_shifted[7:0]};
            F3_LHU:  ld_data = {16'd0, ld_shifted[15:0]};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/stage_memory.sv
// Pipeline memory stage: DTLB translation, byte-enabled data-cache requests, load extension,
// ROB completion and memory exceptions; stalls upstream while a cache access is outstanding.
// Ports: clk/reset; in_* EX/MEM fields + DTLB result; out_dc_*/in_dc_* cache; out_stall; out_* MEM/WB.
// Optional MEM_MISALIGN_CHECK_EN: misaligned half/word raise EXC_MISALIGNED instead of being aligned down.
module stage_memory
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_flush,
    input  logic [31:0] in_alu_out,
    input  logic [31:0] in_mem_in_data,
    input  logic [2:0]  in_funct3,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic        in_mem_to_reg,
    input  logic        in_write_enable,
    input  logic [4:0]  in_rd,
    input  logic [2:0]  in_instr_type,
    input  logic [2:0]  in_exception_vector,
    input  logic [3:0]  in_complete_idx,
    input  logic        in_supervisor_mode,
    input  logic        in_dtlb_hit,
    input  logic [31:0] in_dtlb_paddr,
    output logic        out_dc_req,
    output logic        out_dc_write,
    output logic [31:0] out_dc_addr,
    output logic [31:0] out_dc_wdata,
    output logic [3:0]  out_dc_byte_en,
    input  logic        in_dc_ready,
    input  logic        in_dc_rvalid,
    input  logic [31:0] in_dc_rdata,
    output logic        out_stall,
    output logic        out_valid,
    output logic [4:0]  out_rd,
    output logic [31:0] out_alu_out,
    output logic [31:0] out_mem_data,
    output logic        out_mem_to_reg,
    output logic        out_write_enable,
    output logic [2:0]  out_exception_vector,
    output logic        out_complete,
    output logic [3:0]  out_complete_idx
);

    mem_state_e  state_q, state_d;

    // Outstanding request
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        write_q;
    logic [2:0]  funct3_q;

    // MEM/WB entry
    logic        valid_q, valid_d;
    logic [4:0]  rd_q;
    logic [31:0] alu_q;
    logic [31:0] mem_data_q;
    logic        m2r_q;
    logic        we_q;
    logic [2:0]  exc_q, exc_d;
    logic [3:0]  idx_q;
    logic [2:0]  itype_q;

    logic        accept, is_mem, tlb_miss, misaligned, go_mem, st_done, ld_done;
    logic [31:0] paddr_raw, paddr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata, ld_data;

    assign accept    = (state_q == ST_IDLE) && in_valid && !in_flush;
    assign is_mem    = in_mem_read || in_mem_write;
    assign paddr_raw = in_supervisor_mode ? in_alu_out : in_dtlb_paddr;
    assign paddr     = align_addr(in_funct3, paddr_raw);
    assign tlb_miss  = !in_supervisor_mode && !in_dtlb_hit;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = is_misaligned(in_funct3, paddr_raw[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    // Upstream exceptions take precedence; otherwise misalignment before translation fault.
    always_comb begin
        exc_d = EXC_NONE;
        if (in_exception_vector != EXC_NONE) begin
            exc_d = in_exception_vector;
        end else if (is_mem && misaligned) begin
            exc_d = EXC_MISALIGNED;
        end else if (is_mem && tlb_miss) begin
            exc_d = EXC_DTLB_MISS;
        end
    end

    assign go_mem  = accept && is_mem && (exc_d == EXC_NONE);
    assign st_done = (state_q == ST_REQ) && in_dc_ready && !in_flush && write_q;
    assign ld_done = (state_q == ST_WAIT) && in_dc_rvalid && !in_flush;
    assign valid_d = (accept && !go_mem) || st_done || ld_done;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (go_mem) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (in_flush) begin
                    state_d = ST_IDLE;
                end else if (in_dc_ready) begin
                    state_d = write_q ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Flush coinciding with the response consumes it; no need to drain.
                if (in_dc_rvalid) begin
                    state_d = ST_IDLE;
                end else if (in_flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (in_dc_rvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mem_align u_align (
        .req_funct3  (in_funct3),
        .req_offset  (paddr[1:0]),
        .req_data    (in_mem_in_data),
        .req_byte_en (req_be),
        .req_wdata   (req_wdata),
        .ld_funct3   (funct3_q),
        .ld_offset   (addr_q[1:0]),
        .ld_rdata    (in_dc_rdata),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            write_q    <= 1'b0;
            funct3_q   <= '0;
            valid_q    <= 1'b0;
            rd_q       <= '0;
            alu_q      <= '0;
            mem_data_q <= '0;
            m2r_q      <= 1'b0;
            we_q       <= 1'b0;
            exc_q      <= EXC_NONE;
            idx_q      <= '0;
            itype_q    <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            if (accept) begin
                rd_q       <= in_rd;
                alu_q      <= in_alu_out;
                mem_data_q <= '0;
                m2r_q      <= in_mem_to_reg;
                we_q       <= in_write_enable;
                exc_q      <= exc_d;
                idx_q      <= in_complete_idx;
                itype_q    <= in_instr_type;
            end
            if (go_mem) begin
                addr_q   <= paddr;
                wdata_q  <= req_wdata;
                be_q     <= req_be;
                write_q  <= in_mem_write;
                funct3_q <= in_funct3;
            end
            if (ld_done) begin
                mem_data_q <= ld_data;
            end
        end
    end

    assign out_stall            = (state_q != ST_IDLE);
    assign out_dc_req           = (state_q == ST_REQ);
    assign out_dc_write         = (state_q == ST_REQ) && write_q;
    assign out_dc_addr          = addr_q;
    assign out_dc_wdata         = wdata_q;
    assign out_dc_byte_en       = be_q;
    assign out_valid            = valid_q;
    assign out_rd               = rd_q;
    assign out_alu_out          = alu_q;
    assign out_mem_data         = mem_data_q;
    assign out_mem_to_reg       = m2r_q;
    assign out_write_enable     = we_q;
    assign out_exception_vector = exc_q;
    assign out_complete         = valid_q && ((itype_q == ITYPE_LOAD) || (itype_q == ITYPE_STORE));
    assign out_complete_idx     = idx_q;

endmodule

// File: tb/tb_stage_memory.sv
module tb_stage_memory;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_flush;
    logic [31:0] in_alu_out, in_mem_in_data;
    logic [2:0]  in_funct3;
    logic        in_mem_read, in_mem_write, in_mem_to_reg, in_write_enable;
    logic [4:0]  in_rd;
    logic [2:0]  in_instr_type, in_exception_vector;
    logic [3:0]  in_complete_idx;
    logic        in_supervisor_mode, in_dtlb_hit;
    logic [31:0] in_dtlb_paddr;
    logic        out_dc_req, out_dc_write;
    logic [31:0] out_dc_addr, out_dc_wdata;
    logic [3:0]  out_dc_byte_en;
    logic        in_dc_ready, in_dc_rvalid;
    logic [31:0] in_dc_rdata;
    logic        out_stall, out_valid;
    logic [4:0]  out_rd;
    logic [31:0] out_alu_out, out_mem_data;
    logic        out_mem_to_reg, out_write_enable;
    logic [2:0]  out_exception_vector;
    logic        out_complete;
    logic [3:0]  out_complete_idx;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] data;
        logic        chk_data;
        logic        m2r;
        logic        we;
        logic [2:0]  exc;
        logic        cmp;
        logic [3:0]  idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    stage_memory dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_flush(in_flush),
        .in_alu_out(in_alu_out), .in_mem_in_data(in_mem_in_data), .in_funct3(in_funct3),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
        .in_write_enable(in_write_enable), .in_rd(in_rd), .in_instr_type(in_instr_type),
        .in_exception_vector(in_exception_vector), .in_complete_idx(in_complete_idx),
        .in_supervisor_mode(in_supervisor_mode), .in_dtlb_hit(in_dtlb_hit),
        .in_dtlb_paddr(in_dtlb_paddr), .out_dc_req(out_dc_req), .out_dc_write(out_dc_write),
        .out_dc_addr(out_dc_addr), .out_dc_wdata(out_dc_wdata), .out_dc_byte_en(out_dc_byte_en),
        .in_dc_ready(in_dc_ready), .in_dc_rvalid(in_dc_rvalid), .in_dc_rdata(in_dc_rdata),
        .out_stall(out_stall), .out_valid(out_valid), .out_rd(out_rd), .out_alu_out(out_alu_out),
        .out_mem_data(out_mem_data), .out_mem_to_reg(out_mem_to_reg),
        .out_write_enable(out_write_enable), .out_exception_vector(out_exception_vector),
        .out_complete(out_complete), .out_complete_idx(out_complete_idx)
    );

    always #5 clk = ~clk;

    // Scoreboard: every out_valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out_valid: got rd=%0d alu=%h, expected no output", out_rd, out_alu_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_rd !== mon_e.rd || out_alu_out !== mon_e.alu || out_mem_to_reg !== mon_e.m2r ||
                    out_write_enable !== mon_e.we || out_exception_vector !== mon_e.exc ||
                    out_complete !== mon_e.cmp || out_complete_idx !== mon_e.idx ||
                    (mon_e.chk_data && out_mem_data !== mon_e.data)) begin
                    failures++;
                    $display("FAIL scoreboard: got rd=%0d alu=%h data=%h m2r=%b we=%b exc=%0d cmp=%b idx=%0d, expected rd=%0d alu=%h data=%h m2r=%b we=%b exc=%0d cmp=%b idx=%0d",
                             out_rd, out_alu_out, out_mem_data, out_mem_to_reg, out_write_enable,
                             out_exception_vector, out_complete, out_complete_idx, mon_e.rd, mon_e.alu,
                             mon_e.data, mon_e.m2r, mon_e.we, mon_e.exc, mon_e.cmp, mon_e.idx);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_flush = 0; in_alu_out = 0; in_mem_in_data = 0; in_funct3 = 0;
        in_mem_read = 0; in_mem_write = 0; in_mem_to_reg = 0; in_write_enable = 0; in_rd = 0;
        in_instr_type = ITYPE_ALU; in_exception_vector = EXC_NONE; in_complete_idx = 0;
        in_supervisor_mode = 0; in_dtlb_hit = 0; in_dtlb_paddr = 0;
        in_dc_ready = 0; in_dc_rvalid = 0; in_dc_rdata = 0;
    endtask

    task automatic present(input logic [2:0] f3, input logic rd_op, input logic wr_op,
                           input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sdata,
                           input logic [2:0] itype, input logic [3:0] idx, input logic sup,
                           input logic hit, input logic [31:0] pa);
        in_valid = 1; in_funct3 = f3; in_mem_read = rd_op; in_mem_write = wr_op;
        in_mem_to_reg = rd_op; in_write_enable = !wr_op; in_rd = rd; in_alu_out = alu;
        in_mem_in_data = sdata; in_instr_type = itype; in_exception_vector = EXC_NONE;
        in_complete_idx = idx; in_supervisor_mode = sup; in_dtlb_hit = hit; in_dtlb_paddr = pa;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] data,
                            input logic chk, input logic m2r, input logic we, input logic [2:0] exc,
                            input logic cmp, input logic [3:0] idx);
        exp_t e;
        e.rd = rd; e.alu = alu; e.data = data; e.chk_data = chk; e.m2r = m2r; e.we = we;
        e.exc = exc; e.cmp = cmp; e.idx = idx;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        cyc(); cyc();
        checks++;
        if (out_valid !== 0 || out_stall !== 0 || out_dc_req !== 0 || out_dc_write !== 0 || out_complete !== 0) begin
            failures++;
            $display("FAIL reset_ctrl: got valid=%b stall=%b req=%b wr=%b cmp=%b, expected all 0",
                     out_valid, out_stall, out_dc_req, out_dc_write, out_complete);
        end
        checks++;
        if (out_dc_byte_en !== 4'b0 || out_write_enable !== 0 || out_mem_to_reg !== 0 || out_exception_vector !== EXC_NONE) begin
            failures++;
            $display("FAIL reset_fields: got be=%b we=%b m2r=%b exc=%0d, expected 0/0/0/%0d",
                     out_dc_byte_en, out_write_enable, out_mem_to_reg, out_exception_vector, EXC_NONE);
        end
        checks++;
        if (out_dc_addr !== 0 || out_dc_wdata !== 0 || out_mem_data !== 0 || out_alu_out !== 0 || out_rd !== 0 || out_complete_idx !== 0) begin
            failures++;
            $display("FAIL reset_data: got addr=%h wdata=%h mdata=%h alu=%h rd=%0d idx=%0d, expected all 0",
                     out_dc_addr, out_dc_wdata, out_mem_data, out_alu_out, out_rd, out_complete_idx);
        end
        reset = 0;
        cyc();
    endtask

    task automatic test_nonmem();
        present(3'b000, 0, 0, 5'd7, 32'h1234_5678, 0, ITYPE_ALU, 4'd3, 1, 0, 0);
        push_exp(5'd7, 32'h1234_5678, 0, 0, 0, 1, EXC_NONE, 0, 4'd3);
        cyc();
        idle_inputs();
        checks++;
        if (out_valid !== 1 || out_stall !== 0 || out_dc_req !== 0) begin
            failures++;
            $display("FAIL nonmem_latency: got valid=%b stall=%b req=%b, expected 1/0/0", out_valid, out_stall, out_dc_req);
        end
        cyc();
        checks++;
        if (out_valid !== 0) begin
            failures++;
            $display("FAIL nonmem_pulse: got valid=%b, expected 0", out_valid);
        end
        // Load carrying an upstream exception skips the cache
        present(F3_LW, 1, 0, 5'd8, 32'h0000_0040, 0, ITYPE_LOAD, 4'd5, 1, 1, 32'h40);
        in_exception_vector = 3'd2;
        push_exp(5'd8, 32'h0000_0040, 0, 0, 1, 1, 3'd2, 1, 4'd5);
        cyc();
        idle_inputs();
        checks++;
        if (out_valid !== 1 || out_dc_req !== 0 || out_stall !== 0) begin
            failures++;
            $display("FAIL upstream_exc: got valid=%b req=%b stall=%b, expected 1/0/0", out_valid, out_dc_req, out_stall);
        end
        cyc();
    endtask

    task automatic test_lb();
        present(F3_LB, 1, 0, 5'd5, 32'h0000_0103, 0, ITYPE_LOAD, 4'd4, 1, 0, 32'hDEAD_0000);
        push_exp(5'd5, 32'h0000_0103, 32'hFFFF_FF80, 1, 1, 1, EXC_NONE, 1, 4'd4);
        cyc();
        idle_inputs();
        in_dc_ready = 1;
        checks++;
        if (out_stall !== 1 || out_dc_req !== 1 || out_dc_write !== 0 || out_dc_addr !== 32'h103 || out_dc_byte_en !== 4'b1000) begin
            failures++;
            $display("FAIL lb_req: got stall=%b req=%b wr=%b addr=%h be=%b, expected 1/1/0/00000103/1000",
                     out_stall, out_dc_req, out_dc_write, out_dc_addr, out_dc_byte_en);
        end
        cyc();
        in_dc_ready = 0;
        checks++;
        if (out_dc_req !== 0 || out_stall !== 1 || out_valid !== 0) begin
            failures++;
            $display("FAIL lb_wait: got req=%b stall=%b valid=%b, expected 0/1/0", out_dc_req, out_stall, out_valid);
        end
        in_dc_rvalid = 1;
        in_dc_rdata = 32'h80FF_0000;
        cyc();
        in_dc_rvalid = 0;
        checks++;
        if (out_valid !== 1 || out_stall !== 0) begin
            failures++;
            $display("FAIL lb_latency: got valid=%b stall=%b three cycles after accept, expected 1/0", out_valid, out_stall);
        end
        cyc();
    endtask

    task automatic test_sh();
        present(F3_SH, 0, 1, 5'd0, 32'h7000_0202, 32'h1234_ABCD, ITYPE_STORE, 4'd9, 0, 1, 32'h0000_0202);
        push_exp(5'd0, 32'h7000_0202, 0, 0, 0, 0, EXC_NONE, 1, 4'd9);
        cyc();
        idle_inputs();
        in_dc_ready = 1;
        checks++;
        if (out_dc_req !== 1 || out_dc_write !== 1 || out_dc_addr !== 32'h202 || out_dc_wdata !== 32'hABCD_ABCD || out_dc_byte_en !== 4'b1100) begin
            failures++;
            $display("FAIL sh_req: got req=%b wr=%b addr=%h wdata=%h be=%b, expected 1/1/00000202/abcdabcd/1100",
                     out_dc_req, out_dc_write, out_dc_addr, out_dc_wdata, out_dc_byte_en);
        end
        cyc();
        in_dc_ready = 0;
        checks++;
        if (out_valid !== 1 || out_complete !== 1 || out_complete_idx !== 4'd9 || out_stall !== 0) begin
            failures++;
            $display("FAIL sh_complete: got valid=%b cmp=%b idx=%0d stall=%b, expected 1/1/9/0",
                     out_valid, out_complete, out_complete_idx, out_stall);
        end
        cyc();
    endtask

    task automatic test_lw_delayed();
        present(F3_LW, 1, 0, 5'd12, 32'h0000_0400, 0, ITYPE_LOAD, 4'd6, 1, 0, 0);
        push_exp(5'd12, 32'h0000_0400, 32'hDEAD_BEEF, 1, 1, 1, EXC_NONE, 1, 4'd6);
        cyc();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_stall !== 1 || out_dc_req !== 1 || out_dc_addr !== 32'h400 || out_dc_byte_en !== 4'b1111 || out_valid !== 0) begin
                failures++;
                $display("FAIL lw_hold[%0d]: got stall=%b req=%b addr=%h be=%b valid=%b, expected 1/1/00000400/1111/0",
                         i, out_stall, out_dc_req, out_dc_addr, out_dc_byte_en, out_valid);
            end
            cyc();
        end
        in_dc_ready = 1;
        cyc();
        in_dc_ready = 0;
        cyc();
        checks++;
        if (out_stall !== 1 || out_valid !== 0) begin
            failures++;
            $display("FAIL lw_wait: got stall=%b valid=%b, expected 1/0", out_stall, out_valid);
        end
        in_dc_rvalid = 1;
        in_dc_rdata = 32'hDEAD_BEEF;
        cyc();
        in_dc_rvalid = 0;
        checks++;
        if (out_valid !== 1) begin
            failures++;
            $display("FAIL lw_done: got valid=%b, expected 1", out_valid);
        end
        cyc();
        checks++;
        if (out_valid !== 0) begin
            failures++;
            $display("FAIL lw_pulse: got valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_dtlb_miss();
        present(F3_LW, 1, 0, 5'd3, 32'h0000_0500, 0, ITYPE_LOAD, 4'd2, 0, 0, 0);
        push_exp(5'd3, 32'h0000_0500, 0, 0, 1, 1, EXC_DTLB_MISS, 1, 4'd2);
        cyc();
        idle_inputs();
        checks++;
        if (out_dc_req !== 0 || out_stall !== 0 || out_valid !== 1 || out_exception_vector !== EXC_DTLB_MISS) begin
            failures++;
            $display("FAIL dtlb_miss: got req=%b stall=%b valid=%b exc=%0d, expected 0/0/1/%0d",
                     out_dc_req, out_stall, out_valid, out_exception_vector, EXC_DTLB_MISS);
        end
        cyc();
    endtask

    task automatic test_flush_wait();
        present(F3_LW, 1, 0, 5'd10, 32'h0000_0600, 0, ITYPE_LOAD, 4'd7, 1, 0, 0);
        cyc();
        idle_inputs();
        in_dc_ready = 1;
        cyc();
        in_dc_ready = 0;
        in_flush = 1;
        cyc();
        in_flush = 0;
        checks++;
        if (out_stall !== 1 || out_valid !== 0) begin
            failures++;
            $display("FAIL flush_drain: got stall=%b valid=%b, expected 1/0", out_stall, out_valid);
        end
        cyc();
        in_dc_rvalid = 1;
        in_dc_rdata = 32'h1111_2222;
        cyc();
        in_dc_rvalid = 0;
        checks++;
        if (out_stall !== 0 || out_valid !== 0) begin
            failures++;
            $display("FAIL flush_discard: got stall=%b valid=%b, expected 0/0", out_stall, out_valid);
        end
        present(3'b000, 0, 0, 5'd9, 32'h0000_0099, 0, ITYPE_ALU, 4'd1, 1, 0, 0);
        push_exp(5'd9, 32'h0000_0099, 0, 0, 0, 1, EXC_NONE, 0, 4'd1);
        cyc();
        idle_inputs();
        checks++;
        if (out_valid !== 1) begin
            failures++;
            $display("FAIL flush_next: got valid=%b, expected 1", out_valid);
        end
        cyc();
    endtask

    task automatic test_flush_req_idle();
        present(F3_SW, 0, 1, 5'd0, 32'h0000_0700, 32'h5555_5555, ITYPE_STORE, 4'd8, 1, 0, 0);
        cyc();
        idle_inputs();
        in_dc_ready = 1;
        in_flush = 1;
        cyc();
        idle_inputs();
        checks++;
        if (out_stall !== 0 || out_valid !== 0 || out_dc_req !== 0) begin
            failures++;
            $display("FAIL flush_req: got stall=%b valid=%b req=%b, expected 0/0/0", out_stall, out_valid, out_dc_req);
        end
        present(3'b000, 0, 0, 5'd4, 32'h0000_0044, 0, ITYPE_ALU, 4'd0, 1, 0, 0);
        in_flush = 1;
        cyc();
        idle_inputs();
        checks++;
        if (out_valid !== 0) begin
            failures++;
            $display("FAIL flush_idle: got valid=%b, expected 0", out_valid);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        present(F3_LW, 1, 0, 5'd11, 32'h0000_0800, 0, ITYPE_LOAD, 4'd10, 1, 0, 0);
        cyc();
        idle_inputs();
        in_dc_ready = 1;
        cyc();
        in_dc_ready = 0;
        reset = 1;
        cyc();
        reset = 0;
        checks++;
        if (out_stall !== 0 || out_dc_req !== 0) begin
            failures++;
            $display("FAIL reset_mid: got stall=%b req=%b, expected 0/0", out_stall, out_dc_req);
        end
        in_dc_rvalid = 1;
        in_dc_rdata = 32'h3333_4444;
        cyc();
        in_dc_rvalid = 0;
        checks++;
        if (out_valid !== 0 || out_stall !== 0) begin
            failures++;
            $display("FAIL reset_stray_rvalid: got valid=%b stall=%b, expected 0/0", out_valid, out_stall);
        end
        cyc();
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3_t[4]   = '{F3_LH, F3_LHU, F3_LBU, F3_LB};
        logic [31:0] addr_t[4] = '{32'h2, 32'h2, 32'h1, 32'h0};
        logic [31:0] rd_t[4]   = '{32'h8001_1234, 32'h8001_1234, 32'h0000_A500, 32'h0000_007F};
        logic [31:0] exp_t_[4] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_00A5, 32'h0000_007F};
        logic [3:0]  be_t[4]   = '{4'b1100, 4'b1100, 4'b0010, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            present(f3_t[i], 1, 0, 5'(20 + i), addr_t[i], 0, ITYPE_LOAD, 4'(i), 1, 0, 0);
            push_exp(5'(20 + i), addr_t[i], exp_t_[i], 1, 1, 1, EXC_NONE, 1, 4'(i));
            cyc();
            idle_inputs();
            in_dc_ready = 1;
            checks++;
            if (out_dc_byte_en !== be_t[i] || out_dc_addr !== addr_t[i]) begin
                failures++;
                $display("FAIL ld_ext_be[%0d]: got be=%b addr=%h, expected %b/%h", i, out_dc_byte_en, out_dc_addr, be_t[i], addr_t[i]);
            end
            cyc();
            in_dc_ready = 0;
            in_dc_rvalid = 1;
            in_dc_rdata = rd_t[i];
            cyc();
            in_dc_rvalid = 0;
            cyc();
        end
    endtask

    task automatic test_misalign();
        present(F3_LW, 1, 0, 5'd14, 32'h0000_0102, 0, ITYPE_LOAD, 4'd11, 1, 0, 0);
`ifdef MEM_MISALIGN_CHECK_EN
        push_exp(5'd14, 32'h0000_0102, 0, 0, 1, 1, EXC_MISALIGNED, 1, 4'd11);
        cyc();
        idle_inputs();
        checks++;
        if (out_dc_req !== 0 || out_valid !== 1 || out_exception_vector !== EXC_MISALIGNED) begin
            failures++;
            $display("FAIL misalign_exc: got req=%b valid=%b exc=%0d, expected 0/1/%0d",
                     out_dc_req, out_valid, out_exception_vector, EXC_MISALIGNED);
        end
        cyc();
`else
        push_exp(5'd14, 32'h0000_0102, 32'hCAFE_F00D, 1, 1, 1, EXC_NONE, 1, 4'd11);
        cyc();
        idle_inputs();
        in_dc_ready = 1;
        checks++;
        if (out_dc_req !== 1 || out_dc_addr !== 32'h100 || out_dc_byte_en !== 4'b1111) begin
            failures++;
            $display("FAIL misalign_align: got req=%b addr=%h be=%b, expected 1/00000100/1111",
                     out_dc_req, out_dc_addr, out_dc_byte_en);
        end
        cyc();
        in_dc_ready = 0;
        in_dc_rvalid = 1;
        in_dc_rdata = 32'hCAFE_F00D;
        cyc();
        in_dc_rvalid = 0;
        cyc();
`endif
    endtask

    task automatic test_back_to_back();
        present(3'b000, 0, 0, 5'd1, 32'h0000_00A1, 0, ITYPE_ALU, 4'd12, 1, 0, 0);
        push_exp(5'd1, 32'h0000_00A1, 0, 0, 0, 1, EXC_NONE, 0, 4'd12);
        cyc();
        present(3'b000, 0, 0, 5'd2, 32'h0000_00B2, 0, ITYPE_BRANCH, 4'd13, 1, 0, 0);
        push_exp(5'd2, 32'h0000_00B2, 0, 0, 0, 1, EXC_NONE, 0, 4'd13);
        cyc();
        idle_inputs();
        checks++;
        if (out_valid !== 1 || out_rd !== 5'd2) begin
            failures++;
            $display("FAIL b2b_second: got valid=%b rd=%0d, expected 1/2", out_valid, out_rd);
        end
        cyc();
        checks++;
        if (out_valid !== 0) begin
            failures++;
            $display("FAIL b2b_pulse: got valid=%b, expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_lb();
        test_sh();
        test_lw_delayed();
        test_dtlb_miss();
        test_flush_wait();
        test_flush_req_idle();
        test_reset_mid();
        test_load_ext();
        test_misalign();
        test_back_to_back();
        cyc(); cyc();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d outstanding entries, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
